// File: rtl/primus_pipe_alu_if.sv
// Issue/result handshake bundle for the primus pipelined ALU.
// Latency: none, this is wiring only.
// Backpressure: ready_o stalls issue and ready_i stalls result delivery.
interface primus_pipe_alu_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 5
);
    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    logic [3:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [TAG_W-1:0] tag_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;
    logic [TAG_W-1:0] tag_o;
    logic             zero_o;
    logic             illegal_o;

    // ALU side
    modport slave (
        input  flush_i, valid_i, op_i, a_i, b_i, tag_i, ready_i,
        output ready_o, valid_o, result_o, tag_o, zero_o, illegal_o
    );

    // Issue/writeback side
    modport master (
        output flush_i, valid_i, op_i, a_i, b_i, tag_i, ready_i,
        input  ready_o, valid_o, result_o, tag_o, zero_o, illegal_o
    );
endinterface

// File: rtl/primus_pipe_alu.sv
// Pipelined integer ALU: result computed at issue, then carried through LATENCY elastic stages.
// Latency: LATENCY cycles issue-to-valid_o, 1 op/cycle throughput.
// Backpressure: per-stage valid/ready; a stage loads when empty or when its successor moves.
module primus_pipe_alu #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 3,
    parameter int TAG_W   = 5
) (
    input logic              clk_i,
    input logic              rst_ni,
    primus_pipe_alu_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    logic [WIDTH-1:0] res_d;
    logic             zero_d;
    logic             ill_d;
    logic [SH_W-1:0]  shamt;

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] stage_acc;
    logic [WIDTH-1:0]   res_q  [LATENCY];
    logic [TAG_W-1:0]   tag_q  [LATENCY];
    logic [LATENCY-1:0] zero_q;
    logic [LATENCY-1:0] ill_q;

    assign shamt = bus.b_i[SH_W-1:0];

    // Execute: full result and flags from the issue operands, ahead of stage 1
    always_comb begin
        res_d = '0;
        ill_d = 1'b0;
        case (bus.op_i)
            OP_ADD:  res_d = bus.a_i + bus.b_i;
            OP_SUB:  res_d = bus.a_i - bus.b_i;
            OP_AND:  res_d = bus.a_i & bus.b_i;
            OP_OR:   res_d = bus.a_i | bus.b_i;
            OP_XOR:  res_d = bus.a_i ^ bus.b_i;
            OP_SLL:  res_d = bus.a_i << shamt;
            OP_SRL:  res_d = bus.a_i >> shamt;
            OP_SRA:  res_d = $signed(bus.a_i) >>> shamt;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a_i) < $signed(bus.b_i))};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (bus.a_i < bus.b_i)};
            default: ill_d = 1'b1;
        endcase
        zero_d = (res_d == '0);
    end

    // Accept chain from the output back to issue; only valid bits and ready_i feed it
    always_comb begin
        logic acc;
        acc       = bus.ready_i;
        stage_acc = '0;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            acc          = !valid_q[k] || acc;
            stage_acc[k] = acc;
        end
    end

    // Stage occupancy: move valid bits forward, flush clears everything including the issue
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (bus.flush_i) begin
            valid_q <= '0;
        end else begin
            if (stage_acc[0]) valid_q[0] <= bus.valid_i;
            for (int k = 1; k < LATENCY; k++) begin
                if (stage_acc[k]) valid_q[k] <= valid_q[k-1];
            end
        end
    end

    // Stage payload: load only real ops so a stalled or flushed output keeps its data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            zero_q <= '0;
            ill_q  <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                res_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else if (!bus.flush_i) begin
            if (stage_acc[0] && bus.valid_i) begin
                res_q[0]  <= res_d;
                tag_q[0]  <= bus.tag_i;
                zero_q[0] <= zero_d;
                ill_q[0]  <= ill_d;
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (stage_acc[k] && valid_q[k-1]) begin
                    res_q[k]  <= res_q[k-1];
                    tag_q[k]  <= tag_q[k-1];
                    zero_q[k] <= zero_q[k-1];
                    ill_q[k]  <= ill_q[k-1];
                end
            end
        end
    end

    assign bus.ready_o   = stage_acc[0];
    assign bus.valid_o   = valid_q[LATENCY-1];
    assign bus.result_o  = res_q[LATENCY-1];
    assign bus.tag_o     = tag_q[LATENCY-1];
    assign bus.zero_o    = zero_q[LATENCY-1];
    assign bus.illegal_o = ill_q[LATENCY-1];
endmodule

// File: tb/tb_primus_pipe_alu.sv
// Directed bench for primus_pipe_alu with a scoreboard of expected results.
// Latency: checks LATENCY-cycle issue-to-result timing.
// Backpressure: exercises full pipe, toggling ready_i, flush and reset.
module tb_primus_pipe_alu;
    localparam int WIDTH   = 16;
    localparam int LATENCY = 3;
    localparam int TAG_W   = 5;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   delivered = 0;
    exp_t sb[$];

    primus_pipe_alu_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    primus_pipe_alu #(.WIDTH(WIDTH), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
        exp_t e;
        logic [WIDTH-1:0] r;
        r     = '0;
        e.ill = 1'b0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[3:0];
            4'd6: r = a >> b[3:0];
            4'd7: r = WIDTH'($signed(a) >>> b[3:0]);
            4'd8: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'd9: r = (a < b) ? 16'd1 : 16'd0;
            default: e.ill = 1'b1;
        endcase
        e.res  = r;
        e.tag  = tag;
        e.zero = (r == '0);
        return e;
    endfunction

    // Monitor: score deliveries, enforce hold-while-stalled, record accepted issues
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_res;
    logic [TAG_W-1:0] prev_tag;
    logic             prev_zero, prev_ill;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", bus.valid_o, 1);
                chk("hold_result", bus.result_o, prev_res);
                chk("hold_tag", bus.tag_o, prev_tag);
                chk("hold_flags", {bus.zero_o, bus.illegal_o}, {prev_zero, prev_ill});
            end
            if (bus.valid_o && bus.ready_i) begin
                chk("out_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_result", bus.result_o, e.res);
                    chk("sb_tag", bus.tag_o, e.tag);
                    chk("sb_zero", bus.zero_o, e.zero);
                    chk("sb_illegal", bus.illegal_o, e.ill);
                end
                delivered++;
            end
            if (bus.flush_i) sb.delete();
            else if (bus.valid_i && bus.ready_o)
                sb.push_back(model(bus.op_i, bus.a_i, bus.b_i, bus.tag_i));
            prev_stall = bus.valid_o && !bus.ready_i && !bus.flush_i;
            prev_res   = bus.result_o;
            prev_tag   = bus.tag_o;
            prev_zero  = bus.zero_o;
            prev_ill   = bus.illegal_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
        bit acc;
        acc = 1'b0;
        bus.valid_i = 1'b1;
        bus.op_i = op; bus.a_i = a; bus.b_i = b; bus.tag_i = tag;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.ready_o;
            step();
        end
        bus.valid_i = 1'b0;
        chk("issue_accepted", acc, 1);
    endtask

    task automatic run_single(input logic [3:0] op, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                              input logic [WIDTH-1:0] er, input logic ez, input logic ei);
        bit seen;
        seen = 1'b0;
        issue(op, a, b, tag);
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.valid_o) seen = 1'b1;
            else step();
        end
        chk("single_seen", seen, 1);
        chk("single_result", bus.result_o, er);
        chk("single_tag", bus.tag_o, tag);
        chk("single_zero", bus.zero_o, ez);
        chk("single_illegal", bus.illegal_o, ei);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, j;
        logic [WIDTH-1:0] held;
        rst_n = 1'b0;
        bus.flush_i = 0; bus.valid_i = 0; bus.op_i = 0; bus.a_i = 0; bus.b_i = 0;
        bus.tag_i = 0; bus.ready_i = 0;
        #3;
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_outputs", {bus.result_o, bus.tag_o, bus.zero_o, bus.illegal_o}, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Latency and ADD wrap into the sign bit
        bus.ready_i = 1'b1;
        issue(4'd0, 16'h7FFF, 16'h0001, 5'd3);
        for (int i = 1; i < LATENCY; i++) begin
            chk("lat_early", bus.valid_o, 0);
            step();
        end
        chk("lat_valid", bus.valid_o, 1);
        chk("lat_result", bus.result_o, 16'h8000);
        chk("lat_tag", bus.tag_o, 3);
        chk("lat_zero", bus.zero_o, 0);
        step();

        // Directed operation results
        run_single(4'd1, 16'd5, 16'd5, 5'd4, 16'h0000, 1'b1, 1'b0);
        run_single(4'd8, 16'hFFFF, 16'd1, 5'd5, 16'h0001, 1'b0, 1'b0);
        run_single(4'd9, 16'hFFFF, 16'd1, 5'd6, 16'h0000, 1'b1, 1'b0);
        run_single(4'd7, 16'h8000, 16'h0013, 5'd7, 16'hF000, 1'b0, 1'b0);
        run_single(4'd5, 16'h0001, 16'd15, 5'd8, 16'h8000, 1'b0, 1'b0);
        run_single(4'd12, 16'h1234, 16'h5678, 5'd9, 16'h0000, 1'b1, 1'b1);

        // Fill with ready_i low: three accepted, then stall
        bus.ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.valid_i = 1'b1; bus.op_i = 4'd0;
            bus.a_i = 16'(i * 16); bus.b_i = 16'd1; bus.tag_i = 5'(10 + i);
            @(negedge clk);
            chk("full_ready", bus.ready_o, (i < 3) ? 1 : 0);
            step();
        end
        bus.tag_i = 5'd20; bus.ready_i = 1'b1;
        @(negedge clk);
        chk("full_advance_ready", bus.ready_o, 1);
        step();
        bus.valid_i = 1'b0;
        chk("drain_tag0", {bus.valid_o, bus.tag_o}, {1'b1, 5'd11});
        step();
        chk("drain_tag1", {bus.valid_o, bus.tag_o}, {1'b1, 5'd12});
        step();
        chk("drain_tag2", {bus.valid_o, bus.tag_o}, {1'b1, 5'd20});
        step();
        chk("drain_empty", bus.valid_o, 0);
        chk("drain_ready", bus.ready_o, 1);

        // Stream with ready_i toggling 1010...
        d0 = delivered;
        j = 0;
        for (int cyc = 0; cyc < 100 && j < 8; cyc++) begin
            bus.ready_i = (cyc % 2 == 0);
            bus.valid_i = 1'b1;
            bus.op_i = 4'($urandom_range(0, 9));
            bus.a_i = 16'($urandom); bus.b_i = 16'($urandom); bus.tag_i = 5'(j);
            @(negedge clk);
            if (bus.ready_o) j++;
            step();
        end
        bus.valid_i = 1'b0; bus.ready_i = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("toggle_delivered", delivered - d0, 8);
        chk("toggle_sb_empty", sb.size(), 0);

        // Flush a full pipe plus a concurrent issue
        bus.ready_i = 1'b0;
        issue(4'd4, 16'h00F0, 16'h0F0F, 5'd21);
        issue(4'd3, 16'h1000, 16'h0001, 5'd22);
        issue(4'd2, 16'hFFFF, 16'h00AA, 5'd23);
        d0 = delivered;
        bus.valid_i = 1'b1; bus.op_i = 4'd0; bus.a_i = 16'd1; bus.b_i = 16'd1;
        bus.tag_i = 5'd24; bus.flush_i = 1'b1;
        @(negedge clk);
        held = bus.result_o;
        step();
        bus.flush_i = 1'b0; bus.valid_i = 1'b0;
        chk("flush_valid", bus.valid_o, 0);
        chk("flush_data_kept", bus.result_o, held);
        bus.ready_i = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("flush_none_out", delivered - d0, 0);

        // Reset mid-stream
        bus.ready_i = 1'b0;
        issue(4'd0, 16'h0101, 16'h0202, 5'd25);
        issue(4'd0, 16'h0303, 16'h0404, 5'd26);
        issue(4'd0, 16'h0505, 16'h0606, 5'd27);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.valid_o, 0);
        chk("midrst_outputs", {bus.result_o, bus.tag_o, bus.zero_o, bus.illegal_o}, 0);
        step(); step();
        rst_n = 1'b1;
        bus.ready_i = 1'b1;
        step();
        issue(4'd1, 16'd9, 16'd2, 5'd29);
        for (int i = 1; i < LATENCY; i++) begin
            chk("post_rst_early", bus.valid_o, 0);
            step();
        end
        chk("post_rst_valid", bus.valid_o, 1);
        chk("post_rst_result", bus.result_o, 16'd7);
        step(); step();
        chk("end_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
